tsc_mem_arbiter: RTL and testbench
==================================

// Module: tsc_mem_arbiter
// PURPOSE
//  Shares the single-port synchronous program/data memory of the TSC CPU between three requesters:
//  loader/debug port (L), CPU data access (D) and CPU instruction fetch (I).
//  Sits between the cpu core and the memory macro and serialises accesses with a req/ack handshake.
//  One transaction is in flight at a time. Priority is fixed (L > D > I), with an anti-starvation boost for I.
// PARAMETERS
//  WORD_SIZE    16  data width
//  ADDR_W       16  address width
//  MEM_LATENCY   2  cycles from the mem_cs cycle to valid mem_rdata (>=1)
//  STARVE_LIMIT  4  consecutive lost arbitrations after which I wins next (0 = boost disabled)
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  reset_n      in   1          synchronous, active-low reset
//  l_req        in   1          loader request, held until l_ack
//  l_we         in   1          loader write enable (1 = write)
//  l_addr       in   ADDR_W     loader address
//  l_wdata      in   WORD_SIZE  loader write data
//  l_ack        out  1          one-cycle completion pulse to loader
//  d_req        in   1          CPU data request
//  d_we         in   1          CPU data write enable
//  d_addr       in   ADDR_W     CPU data address
//  d_wdata      in   WORD_SIZE  CPU data write data
//  d_ack        out  1          one-cycle completion pulse to CPU data side
//  i_req        in   1          CPU fetch request (read only)
//  i_addr       in   ADDR_W     fetch address (PC)
//  i_ack        out  1          one-cycle completion pulse to fetch side
//  rdata        out  WORD_SIZE  read data, valid in the ack cycle (shared by all requesters)
//  mem_cs       out  1          memory select, one cycle per access
//  mem_we       out  1          memory write enable, qualified by mem_cs
//  mem_addr     out  ADDR_W     memory address
//  mem_wdata    out  WORD_SIZE  memory write data
//  mem_rdata    in   WORD_SIZE  memory read data, valid MEM_LATENCY cycles after the mem_cs cycle
//  busy         out  1          high in every state except IDLE
//  grant_id     out  2          00 none, 01 I, 10 D, 11 L; holds the current owner from ISSUE to RESP
// BEHAVIOUR
//  Reset (reset_n=0 at an edge):
//   - State -> IDLE. All acks, mem_cs, mem_we, busy = 0; grant_id = 00.
//   - rdata, mem_addr and mem_wdata = 0; starvation counter = 0.
//   - A reset mid-transaction abandons it: no ack is produced, and an issued write is not retracted.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   - IDLE: if any req=1 at the edge, choose the winner and latch its we, addr and wdata. Go to ISSUE.
//   - ISSUE (1 cycle): mem_cs=1, mem_we=latched we (0 for I), mem_addr/mem_wdata = latched values.
//   - WAIT: exactly MEM_LATENCY cycles, mem_cs=0. At the last WAIT edge, rdata <= mem_rdata.
//     rdata is also captured for writes; its value is don't-care in that case.
//   - RESP (1 cycle): the winner's ack=1 and rdata is valid. Go to IDLE.
//  Latency: req first high in cycle 0 (arbiter idle) -> ISSUE in cycle 1 -> ack in cycle MEM_LATENCY+2.
//   Back-to-back accesses from one requester start every MEM_LATENCY+3 cycles.
//  Priority: L > D > I, unless the boost is active.
//   - Boost is active when starve_cnt == STARVE_LIMIT (and STARVE_LIMIT != 0); I then wins over L and D.
//   - starve_cnt increments at each IDLE arbitration where i_req=1 and I loses; it saturates at STARVE_LIMIT.
//   - starve_cnt clears when I wins, or when i_req=0 at an arbitration.
//  Handshake:
//   - Requester inputs are sampled only in IDLE; changes after the grant are ignored.
//   - A req dropped before its ack still completes, and the ack still pulses.
//   - A req still high in the cycle after its ack is treated as a new request at the next IDLE edge.
//   - Simultaneous requests: only one winner; losers keep waiting with ack=0.
//  Widths: no arithmetic on addresses or data. The counters are sized by $clog2(param+1).
// TESTING
//  1. MEM_LATENCY=2, i_req=1 with i_addr=16'h0010, memory holds 16'h6A01:
//     mem_cs in cycle 1 only; i_ack=1 with rdata=16'h6A01 in cycle 4; grant_id=01 during cycles 1-4.
//  2. l_req, d_req and i_req all raised in the same cycle, then each dropped after its own ack:
//     service order L, D, I; acks 5 cycles apart; exactly one ack per service.
//  3. D write addr=16'h0020 wdata=16'hBEEF, then I read of 16'h0020:
//     mem_we=1 only in the D ISSUE cycle; I rdata=16'hBEEF.
//  4. d_req held high continuously with i_req=1, STARVE_LIMIT=4:
//     D wins 4 arbitrations, I wins the 5th, then starve_cnt reads 0.
//  5. reset_n=0 during WAIT of an L read: no l_ack; busy=0 and grant_id=00 the next cycle;
//     a fresh i_req after reset is served normally.
//  6. d_req dropped during ISSUE: d_ack still pulses in RESP; there is no second access.

Source files
------------

// File: rtl/tsc_mem_arbiter.sv
// Memory arbiter for the TSC CPU: serialises loader (L), data (D) and fetch (I) accesses
// onto one single-port synchronous memory, fixed priority L > D > I with a starvation boost for I.
module tsc_mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_W       = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 l_req,
    input  logic                 l_we,
    input  logic [ADDR_W-1:0]    l_addr,
    input  logic [WORD_SIZE-1:0] l_wdata,
    output logic                 l_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    localparam int WAIT_W   = $clog2(MEM_LATENCY + 1);
    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MEM_LATENCY);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10,
        GNT_L    = 2'b11
    } grant_t;

    state_t                state;
    grant_t                owner;
    grant_t                winner;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  boost;
    logic                  any_req;
    logic                  win_we;
    logic [ADDR_W-1:0]     win_addr;
    logic [WORD_SIZE-1:0]  win_wdata;

    assign any_req  = l_req | d_req | i_req;
    assign boost    = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
    assign grant_id = owner;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        winner    = GNT_NONE;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (i_req && boost)
            winner = GNT_I;
        else if (l_req)
            winner = GNT_L;
        else if (d_req)
            winner = GNT_D;
        else if (i_req)
            winner = GNT_I;
        case (winner)
            GNT_L: begin
                win_we    = l_we;
                win_addr  = l_addr;
                win_wdata = l_wdata;
            end
            GNT_D: begin
                win_we    = d_we;
                win_addr  = d_addr;
                win_wdata = d_wdata;
            end
            GNT_I:   win_addr = i_addr;
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= GNT_NONE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            busy       <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            l_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_ack      <= 1'b0;
        end else begin
            l_ack <= 1'b0;
            d_ack <= 1'b0;
            i_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ISSUE;
                        owner     <= winner;
                        busy      <= 1'b1;
                        mem_cs    <= 1'b1;
                        mem_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        // Only a fetch that is actually waiting and loses counts toward the boost.
                        if (!i_req || winner == GNT_I)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    mem_cs   <= 1'b0;
                    mem_we   <= 1'b0;
                    wait_cnt <= WAIT_W'(1);
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= RESP;
                        rdata <= mem_rdata;
                        l_ack <= (owner == GNT_L);
                        d_ack <= (owner == GNT_D);
                        i_ack <= (owner == GNT_I);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    owner <= GNT_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tsc_mem_arbiter.sv
// Self-checking bench for tsc_mem_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level reference model and a behavioural memory.
module tb_tsc_mem_arbiter;

    localparam int WS     = 16;
    localparam int AW     = 16;
    localparam int ML     = 2;
    localparam int SL     = 4;
    localparam int ACK_PH = ML + 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          l_req, l_we, l_ack;
    logic [AW-1:0] l_addr;
    logic [WS-1:0] l_wdata;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [WS-1:0] d_wdata;
    logic          i_req, i_ack;
    logic [AW-1:0] i_addr;
    logic [WS-1:0] rdata;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_wdata;
    logic [WS-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    grant_id;

    tsc_mem_arbiter #(
        .WORD_SIZE(WS), .ADDR_W(AW), .MEM_LATENCY(ML), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .rdata(rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Power-up memory contents; 0x0010 holds the known fetch word.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        if (a == 16'h0010)
            return 16'h6A01;
        return {a[7:0] ^ 8'h3C, ~a[7:0]};
    endfunction

    // Behavioural memory macro: data appears ML cycles after the select cycle, garbage otherwise.
    bit   [15:0] mem_arr [65536];
    bit          mem_wr  [65536];
    logic [15:0] rd_pipe [ML];

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                mem_arr[mem_addr] <= mem_wdata;
                mem_wr[mem_addr]  <= 1'b1;
            end
            rd_pipe[0] <= mem_wr[mem_addr] ? mem_arr[mem_addr] : init_word(mem_addr);
        end else begin
            rd_pipe[0] <= 16'($urandom);
        end
        for (int k = 1; k < ML; k++)
            rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[ML-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requester agents, indexed by grant code: 1 = I, 2 = D, 3 = L.
    logic        a_pend [1:3];
    logic        a_req  [1:3];
    logic        a_we   [1:3];
    logic [15:0] a_addr [1:3];
    logic [15:0] a_wdata[1:3];
    logic        rst_drive = 1'b0;
    logic        hold_d    = 1'b0;

    // Reference model: one transaction as a phase count since the grant edge.
    logic [15:0] ref_mem [int];
    int          m_phase = 0;
    int          m_starve = 0;
    int          m_win = 0;
    logic        m_we = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_data = '0;
    logic [15:0] m_rdata = '0;
    logic        m_rd_known = 1'b0;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a)))
            return ref_mem[int'(a)];
        return init_word(a);
    endfunction

    task automatic clear_agents();
        for (int g = 1; g <= 3; g++) begin
            a_pend[g]  = 1'b0;
            a_req[g]   = 1'b0;
            a_we[g]    = 1'b0;
            a_addr[g]  = '0;
            a_wdata[g] = '0;
        end
    endtask

    task automatic arm(input int g, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        a_pend[g]  = 1'b1;
        a_req[g]   = 1'b1;
        a_we[g]    = we;
        a_addr[g]  = addr;
        a_wdata[g] = wd;
    endtask

    task automatic drive_ports();
        l_req = a_req[3]; l_we = a_we[3]; l_addr = a_addr[3]; l_wdata = a_wdata[3];
        d_req = a_req[2]; d_we = a_we[2]; d_addr = a_addr[2]; d_wdata = a_wdata[2];
        i_req = a_req[1]; i_addr = a_addr[1];
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_phase    = 0;
            m_starve   = 0;
            m_addr     = '0;
            m_wdata    = '0;
            m_rdata    = '0;
            m_rd_known = 1'b1;
        end else if (m_phase == 0) begin
            if (l_req || d_req || i_req) begin
                if (i_req && SL != 0 && m_starve == SL) m_win = 1;
                else if (l_req) m_win = 3;
                else if (d_req) m_win = 2;
                else            m_win = 1;
                if (!i_req || m_win == 1) m_starve = 0;
                else if (m_starve < SL)   m_starve = m_starve + 1;
                case (m_win)
                    3:       begin m_we = l_we; m_addr = l_addr; m_wdata = l_wdata; end
                    2:       begin m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; end
                    default: begin m_we = 1'b0; m_addr = i_addr; end
                endcase
                m_data = ref_read(m_addr);
                if (m_we)
                    ref_mem[int'(m_addr)] = m_wdata;
                m_phase = 1;
            end
        end else if (m_phase == ACK_PH) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
        if (reset_n && m_phase == ACK_PH) begin
            m_rdata    = m_data;
            m_rd_known = !m_we;
        end
    endtask

    task automatic run_cycle(input bit rand_en);
        if (rand_en) begin
            if ($urandom_range(0, 255) == 0) begin
                reset_n = 1'b0;
                clear_agents();
            end else begin
                reset_n = 1'b1;
                for (int g = 1; g <= 3; g++) begin
                    if (!a_pend[g]) begin
                        if ($urandom_range(0, 3) == 0)
                            arm(g, (g == 1) ? 1'b0 : 1'($urandom_range(0, 1)),
                                16'($urandom_range(0, 31)), 16'($urandom));
                        else
                            a_req[g] = 1'b0;
                    end else if (m_phase != 0 && m_win == g) begin
                        // Owner may drop its request or change its fields after the grant.
                        if ($urandom_range(0, 5) == 0) a_req[g] = 1'b0;
                        if ($urandom_range(0, 3) == 0) begin
                            a_addr[g]  = 16'($urandom_range(0, 31));
                            a_wdata[g] = 16'($urandom);
                            a_we[g]    = (g == 1) ? 1'b0 : ~a_we[g];
                        end
                    end
                end
            end
        end else begin
            reset_n = rst_drive;
        end
        drive_ports();
        model_step();
        @(posedge clk);
        #1;
        check("busy",     32'(busy),     32'(m_phase != 0));
        check("grant_id", 32'(grant_id), (m_phase != 0) ? 32'(m_win) : 32'd0);
        check("mem_cs",   32'(mem_cs),   32'(m_phase == 1));
        check("mem_we",   32'(mem_we),   32'(m_phase == 1 && m_we));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("l_ack",    32'(l_ack),    32'(m_phase == ACK_PH && m_win == 3));
        check("d_ack",    32'(d_ack),    32'(m_phase == ACK_PH && m_win == 2));
        check("i_ack",    32'(i_ack),    32'(m_phase == ACK_PH && m_win == 1));
        if (!reset_n || (m_phase == 1 && m_we))
            check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        if (m_rd_known)
            check("rdata", 32'(rdata), 32'(m_rdata));
        if (reset_n && m_phase == ACK_PH) begin
            if (!(hold_d && m_win == 2)) begin
                a_pend[m_win] = 1'b0;
                if (!rand_en) a_req[m_win] = 1'b0;
            end
        end
    endtask

    initial begin
        clear_agents();
        reset_n = 1'b0;
        drive_ports();
        repeat (2) run_cycle(1'b0);
        rst_drive = 1'b1;

        // Lone fetch of the known word.
        arm(1, 1'b0, 16'h0010, 16'h0000);
        repeat (8) run_cycle(1'b0);

        // All three at once: L read, D write BEEF, I reads back what D wrote.
        arm(3, 1'b0, 16'h0010, 16'h0000);
        arm(2, 1'b1, 16'h0020, 16'hBEEF);
        arm(1, 1'b0, 16'h0020, 16'h0000);
        repeat (18) run_cycle(1'b0);

        // D never lets go while I waits: the boost must let I in on the fifth arbitration.
        hold_d = 1'b1;
        arm(2, 1'b1, 16'h0005, 16'h1234);
        arm(1, 1'b0, 16'h0003, 16'h0000);
        repeat (30) run_cycle(1'b0);
        hold_d = 1'b0;
        repeat (12) run_cycle(1'b0);

        // Reset during the WAIT of an L read, then a fresh fetch.
        arm(3, 1'b0, 16'h0011, 16'h0000);
        repeat (3) run_cycle(1'b0);
        rst_drive = 1'b0;
        clear_agents();
        run_cycle(1'b0);
        rst_drive = 1'b1;
        arm(1, 1'b0, 16'h0012, 16'h0000);
        repeat (8) run_cycle(1'b0);

        // D drops its request during ISSUE.
        arm(2, 1'b0, 16'h0007, 16'h0000);
        run_cycle(1'b0);
        a_req[2] = 1'b0;
        repeat (8) run_cycle(1'b0);

        repeat (3000) run_cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
